// File: rtl/local_branch_predictor_btb.sv
// Fetch-stage branch predictor: direct-mapped BTB plus a two-level local-history
// direction predictor. Lookup is registered (one-cycle latency); tables self-clear after reset.
module local_branch_predictor_btb #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned BTB_IDX_W = 6,
   parameter int unsigned TAG_W     = 10,
   parameter int unsigned LHT_IDX_W = 5,
   parameter int unsigned HIST_W    = 4,
   parameter int unsigned CTR_W     = 2
) (
   input  logic              clk,
   input  logic              rst,
   output logic              init_done,
   input  logic              lookup_valid,
   input  logic [ADDR_W-1:0] lookup_pc,
   input  logic              lookup_cond,
   output logic              pred_valid,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_cond,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target
);

   localparam int unsigned BTB_N  = 1 << BTB_IDX_W;
   localparam int unsigned LHT_N  = 1 << LHT_IDX_W;
   localparam int unsigned PT_N   = 1 << HIST_W;
   localparam int unsigned INIT_W =
      (BTB_IDX_W >= LHT_IDX_W) ? ((BTB_IDX_W >= HIST_W) ? BTB_IDX_W : HIST_W)
                               : ((LHT_IDX_W >= HIST_W) ? LHT_IDX_W : HIST_W);
   localparam logic [INIT_W-1:0] INIT_LAST  = '1;
   localparam logic [CTR_W-1:0]  CTR_MAX    = '1;
   localparam logic [CTR_W-1:0]  CTR_WEAK_N = {1'b0, {(CTR_W-1){1'b1}}};

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t              state, state_next;
   logic [INIT_W-1:0]   init_cnt, init_cnt_next;
   logic                lookup_acc, upd_acc;

   logic                btb_valid  [BTB_N];
   logic [TAG_W-1:0]    btb_tag    [BTB_N];
   logic [ADDR_W-1:0]   btb_target [BTB_N];
   logic [HIST_W-1:0]   lht        [LHT_N];
   logic [CTR_W-1:0]    pt         [PT_N];

   // Lookup-side decode against current (pre-update) table contents
   logic [BTB_IDX_W-1:0] l_btb_idx;
   logic [TAG_W-1:0]     l_tag;
   logic [LHT_IDX_W-1:0] l_lht_idx;
   logic [HIST_W-1:0]    l_hist;
   logic                 l_hit, l_taken;
   logic [ADDR_W-1:0]    l_target;

   always_comb begin
      l_btb_idx = lookup_pc[BTB_IDX_W-1:0];
      l_tag     = lookup_pc[BTB_IDX_W+TAG_W-1:BTB_IDX_W];
      l_lht_idx = lookup_pc[LHT_IDX_W-1:0];
      l_hist    = lht[l_lht_idx];
      l_hit     = btb_valid[l_btb_idx] && (btb_tag[l_btb_idx] == l_tag);
      l_taken   = l_hit && (!lookup_cond || pt[l_hist][CTR_W-1]);
      l_target  = l_taken ? btb_target[l_btb_idx] : ADDR_W'(lookup_pc + ADDR_W'(1));
   end

   // Update-side decode: pattern counter selected by this branch's history
   logic [BTB_IDX_W-1:0] u_btb_idx;
   logic [TAG_W-1:0]     u_tag;
   logic [LHT_IDX_W-1:0] u_lht_idx;
   logic [HIST_W-1:0]    u_hist;
   logic [CTR_W-1:0]     u_ctr, u_ctr_next;

   always_comb begin
      u_btb_idx = upd_pc[BTB_IDX_W-1:0];
      u_tag     = upd_pc[BTB_IDX_W+TAG_W-1:BTB_IDX_W];
      u_lht_idx = upd_pc[LHT_IDX_W-1:0];
      u_hist    = lht[u_lht_idx];
      u_ctr     = pt[u_hist];
      u_ctr_next = u_ctr;
      if (upd_taken) begin
         if (u_ctr != CTR_MAX) u_ctr_next = u_ctr + CTR_W'(1);
      end else begin
         if (u_ctr != '0) u_ctr_next = u_ctr - CTR_W'(1);
      end
   end

   // Init sweep covers the largest table; smaller tables skip out-of-range indices
   logic btb_init_en, lht_init_en, pt_init_en;
   always_comb begin
      btb_init_en = (init_cnt >> BTB_IDX_W) == '0;
      lht_init_en = (init_cnt >> LHT_IDX_W) == '0;
      pt_init_en  = (init_cnt >> HIST_W) == '0;
   end

   always_comb begin
      state_next    = state;
      init_cnt_next = init_cnt;
      lookup_acc    = 1'b0;
      upd_acc       = 1'b0;
      case (state)
         S_INIT: begin
            init_cnt_next = init_cnt + INIT_W'(1);
            if (init_cnt == INIT_LAST) state_next = S_RUN;
         end
         S_RUN: begin
            lookup_acc = lookup_valid;
            upd_acc    = upd_valid;
         end
         default: state_next = S_INIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_INIT;
         init_cnt    <= '0;
         init_done   <= 1'b0;
         pred_valid  <= 1'b0;
         pred_hit    <= 1'b0;
         pred_taken  <= 1'b0;
         pred_target <= '0;
      end else begin
         state      <= state_next;
         init_cnt   <= init_cnt_next;
         init_done  <= (state_next == S_RUN);
         pred_valid <= lookup_acc;
         if (lookup_acc) begin
            pred_hit    <= l_hit;
            pred_taken  <= l_taken;
            pred_target <= l_target;
         end
      end
   end

   // Table storage: cleared by the INIT sweep, so no reset term is needed
   always_ff @(posedge clk) begin
      if (state == S_INIT) begin
         if (btb_init_en) btb_valid[init_cnt[BTB_IDX_W-1:0]] <= 1'b0;
         if (lht_init_en) lht[init_cnt[LHT_IDX_W-1:0]] <= '0;
         if (pt_init_en)  pt[init_cnt[HIST_W-1:0]] <= CTR_WEAK_N;
      end else if (upd_acc) begin
         if (upd_taken) begin
            btb_valid[u_btb_idx]  <= 1'b1;
            btb_tag[u_btb_idx]    <= u_tag;
            btb_target[u_btb_idx] <= upd_target;
         end
         if (upd_cond) begin
            pt[u_hist]       <= u_ctr_next;
            lht[u_lht_idx]   <= {u_hist[HIST_W-2:0], upd_taken};
         end
      end
   end

   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc, upd_pc};

endmodule

// File: tb/tb_local_branch_predictor_btb.sv
// Directed bench for local_branch_predictor_btb: init sweep timing, BTB training,
// local-history direction training with saturation, read-old collisions and mid-run reset.
module tb_local_branch_predictor_btb;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned INIT_CYCLES = 64;

   logic              clk = 1'b0;
   logic              rst;
   logic              init_done;
   logic              lookup_valid;
   logic [ADDR_W-1:0] lookup_pc;
   logic              lookup_cond;
   logic              pred_valid;
   logic              pred_hit;
   logic              pred_taken;
   logic [ADDR_W-1:0] pred_target;
   logic              upd_valid;
   logic [ADDR_W-1:0] upd_pc;
   logic              upd_cond;
   logic              upd_taken;
   logic [ADDR_W-1:0] upd_target;

   int total = 0;
   int bad   = 0;

   local_branch_predictor_btb dut (
      .clk          (clk),
      .rst          (rst),
      .init_done    (init_done),
      .lookup_valid (lookup_valid),
      .lookup_pc    (lookup_pc),
      .lookup_cond  (lookup_cond),
      .pred_valid   (pred_valid),
      .pred_hit     (pred_hit),
      .pred_taken   (pred_taken),
      .pred_target  (pred_target),
      .upd_valid    (upd_valid),
      .upd_pc       (upd_pc),
      .upd_cond     (upd_cond),
      .upd_taken    (upd_taken),
      .upd_target   (upd_target)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_pred(input string tag, input logic hit, input logic taken,
                             input logic [ADDR_W-1:0] tgt);
      check({tag, ".valid"},  64'(pred_valid), 64'(1'b1));
      check({tag, ".hit"},    64'(pred_hit), 64'(hit));
      check({tag, ".taken"},  64'(pred_taken), 64'(taken));
      check({tag, ".target"}, 64'(pred_target), 64'(tgt));
   endtask

   task automatic do_upd(input logic [ADDR_W-1:0] pc, input logic cond, input logic taken,
                         input logic [ADDR_W-1:0] tgt);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_cond   = cond;
      upd_taken  = taken;
      upd_target = tgt;
      step();
      upd_valid  = 1'b0;
   endtask

   task automatic do_lookup(input logic [ADDR_W-1:0] pc, input logic cond);
      lookup_valid = 1'b1;
      lookup_pc    = pc;
      lookup_cond  = cond;
      step();
      lookup_valid = 1'b0;
   endtask

   // Init sweep: lookups and updates held active must have no effect
   task automatic run_init(input string tag);
      lookup_valid = 1'b1;
      lookup_pc    = 32'h100;
      lookup_cond  = 1'b1;
      upd_valid    = 1'b1;
      upd_pc       = 32'h100;
      upd_cond     = 1'b1;
      upd_taken    = 1'b1;
      upd_target   = 32'h999;
      for (int k = 1; k <= INIT_CYCLES; k++) begin
         step();
         check({tag, ".init_done"}, 64'(init_done), 64'(k == INIT_CYCLES));
         check({tag, ".no_pred"},   64'(pred_valid), 64'(1'b0));
      end
      lookup_valid = 1'b0;
      upd_valid    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst          = 1'b1;
      lookup_valid = 1'b0;
      lookup_pc    = '0;
      lookup_cond  = 1'b0;
      upd_valid    = 1'b0;
      upd_pc       = '0;
      upd_cond     = 1'b0;
      upd_taken    = 1'b0;
      upd_target   = '0;
      step();
      step();
      check("rst.init_done",   64'(init_done), 64'(0));
      check("rst.pred_valid",  64'(pred_valid), 64'(0));
      check("rst.pred_hit",    64'(pred_hit), 64'(0));
      check("rst.pred_taken",  64'(pred_taken), 64'(0));
      check("rst.pred_target", 64'(pred_target), 64'(0));
      rst = 1'b0;
      run_init("init1");

      // Cold miss; the update dropped during INIT must not have trained 0x100
      do_lookup(32'h100, 1'b1);
      check_pred("cold", 1'b0, 1'b0, 32'h101);
      step();
      check("hold.valid",  64'(pred_valid), 64'(0));
      check("hold.target", 64'(pred_target), 64'(32'h101));

      // Unconditional training and tag alias
      do_upd(32'h200, 1'b0, 1'b1, 32'h340);
      do_lookup(32'h200, 1'b0);
      check_pred("jal_hit", 1'b1, 1'b1, 32'h340);
      do_lookup(32'h240, 1'b0);
      check_pred("alias", 1'b0, 1'b0, 32'h241);
      do_lookup(32'h200, 1'b1);
      check_pred("jal_as_cond", 1'b1, 1'b0, 32'h201);
      do_lookup(32'hFFFF_FFFF, 1'b0);
      check_pred("wrap", 1'b0, 1'b0, 32'h0);

      // Conditional training at 0x104: history 0->1->3->7->15
      do_upd(32'h104, 1'b1, 1'b1, 32'h080);
      do_lookup(32'h104, 1'b1);
      check_pred("cond1", 1'b1, 1'b0, 32'h105);
      do_upd(32'h104, 1'b1, 1'b1, 32'h080);
      do_upd(32'h104, 1'b1, 1'b1, 32'h080);
      do_upd(32'h104, 1'b1, 1'b1, 32'h080);
      do_lookup(32'h104, 1'b1);
      check_pred("cond4", 1'b1, 1'b0, 32'h105);
      do_upd(32'h104, 1'b1, 1'b1, 32'h080);
      do_lookup(32'h104, 1'b1);
      check_pred("cond5", 1'b1, 1'b1, 32'h080);
      do_upd(32'h104, 1'b1, 1'b1, 32'h080);
      do_upd(32'h104, 1'b1, 1'b1, 32'h080);

      // Observers 0x105 and 0x106 reach history 15 to watch PT[15]
      for (int i = 0; i < 4; i++) do_upd(32'h105, 1'b1, 1'b1, 32'h0A0);
      do_lookup(32'h105, 1'b1);
      check_pred("sat3", 1'b1, 1'b1, 32'h0A0);
      for (int i = 0; i < 4; i++) do_upd(32'h106, 1'b1, 1'b1, 32'h0C0);
      do_upd(32'h104, 1'b1, 1'b0, 32'h080);
      do_lookup(32'h105, 1'b1);
      check_pred("dec3to2", 1'b1, 1'b1, 32'h0A0);
      do_upd(32'h105, 1'b1, 1'b0, 32'h0A0);
      do_lookup(32'h106, 1'b1);
      check_pred("dec2to1", 1'b1, 1'b0, 32'h107);
      do_lookup(32'h104, 1'b0);
      check_pred("nt_keeps_btb", 1'b1, 1'b1, 32'h080);

      // Same-cycle lookup and update: read-old, then back-to-back lookups
      lookup_valid = 1'b1;
      lookup_pc    = 32'h300;
      lookup_cond  = 1'b0;
      do_upd(32'h300, 1'b0, 1'b1, 32'h3A0);
      check_pred("same_cycle", 1'b0, 1'b0, 32'h301);
      step();
      check_pred("after_upd", 1'b1, 1'b1, 32'h3A0);
      lookup_pc = 32'h200;
      step();
      lookup_valid = 1'b0;
      check_pred("overwritten", 1'b0, 1'b0, 32'h201);

      // Reset mid-RUN with an accepted lookup in flight
      lookup_valid = 1'b1;
      lookup_pc    = 32'h300;
      step();
      rst = 1'b1;
      #1;
      check("rst2.pred_valid",  64'(pred_valid), 64'(0));
      check("rst2.init_done",   64'(init_done), 64'(0));
      check("rst2.pred_target", 64'(pred_target), 64'(0));
      lookup_valid = 1'b0;
      step();
      step();
      rst = 1'b0;
      run_init("init2");
      do_lookup(32'h300, 1'b0);
      check_pred("post_rst_300", 1'b0, 1'b0, 32'h301);
      do_lookup(32'h104, 1'b1);
      check_pred("post_rst_104", 1'b0, 1'b0, 32'h105);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
